stack_arbiter: RTL

Controller that shares one stack instance between two requesters: requester 0 is the control unit (CALL/RET), requester 1 is the datapath (PUSH/POP instructions). It arbitrates round-robin and sequences single-cycle push/pop strobes into the stack. It captures pop data and returns a registered response. It keeps its own occupancy count and rejects overflow and underflow before they reach the stack.

---
 rtl/stack_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/stack_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack arbiter slice.
//   - default data width and stack depth
//   - requester op encoding (push/pop)
//   - FSM state encoding for stack_arbiter
package stack_pkg;

  localparam int unsigned DEF_WIDTH_DATA = 16;
  localparam int unsigned DEF_DEPTH      = 10;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_ISSUE    = 2'd1;
  localparam state_t ST_WAIT_POP = 2'd2;
  localparam state_t ST_RESP     = 2'd3;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant with a last-grant pointer.
// Ports:
//   clk, reset    clock, asynchronous active-low reset
//   i_req0/1      request lines
//   i_update      load the last-grant pointer with i_upd_id
//   i_upd_id      id that was just served
//   o_gnt_valid   at least one request present
//   o_gnt_id      winning requester (0 or 1)
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_update,
  input  logic i_upd_id,
  output logic o_gnt_valid,
  output logic o_gnt_id
);

  logic r_last;

  // Pointer starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= 1'b1;
    end else if (i_update) begin
      r_last <= i_upd_id;
    end
  end

  always_comb begin
    o_gnt_valid = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_gnt_id = ~r_last;
    end else begin
      o_gnt_id = i_req1;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one stack between two requesters (r0: control unit CALL/RET,
// r1: datapath PUSH/POP). Round-robin grant, single-cycle push/pop strobes,
// registered response, own occupancy count with overflow/underflow rejection.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   rX_valid/op/data           request (held until rX_ready), op 0=push 1=pop
//   rX_ready                   one-cycle accept pulse
//   rX_rsp_valid/data/err      one-cycle response, popped word, error flag
//   stk_push/pop/data_in       strobes and write data towards the stack
//   stk_data_out               stack read data, valid the cycle after stk_pop
//   stk_full/empty             stack status flags
//   occupancy                  words currently held
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = DEF_WIDTH_DATA,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_valid,
  input  logic                  r0_op,
  input  logic [WIDTH_DATA-1:0] r0_data,
  output logic                  r0_ready,
  output logic                  r0_rsp_valid,
  output logic [WIDTH_DATA-1:0] r0_rsp_data,
  output logic                  r0_err,
  input  logic                  r1_valid,
  input  logic                  r1_op,
  input  logic [WIDTH_DATA-1:0] r1_data,
  output logic                  r1_ready,
  output logic                  r1_rsp_valid,
  output logic [WIDTH_DATA-1:0] r1_rsp_data,
  output logic                  r1_err,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [WIDTH_DATA-1:0] stk_data_in,
  input  logic [WIDTH_DATA-1:0] stk_data_out,
  input  logic                  stk_full,
  input  logic                  stk_empty,
  output logic [CNT_W-1:0]      occupancy
);

  state_t                r_state;
  logic                  r_id;
  logic                  r_op;
  logic                  r_err;
  logic [WIDTH_DATA-1:0] r_data;
  logic [WIDTH_DATA-1:0] r_rsp_data;
  logic [CNT_W-1:0]      r_occ;

  logic                  w_gnt_valid;
  logic                  w_gnt_id;
  logic                  w_grant;
  logic                  w_op;
  logic [WIDTH_DATA-1:0] w_data;
  logic                  w_ovf;
  logic                  w_unf;
  logic                  w_resp;
  logic                  w_issue;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .reset       (reset),
    .i_req0      (r0_valid),
    .i_req1      (r1_valid),
    .i_update    (w_resp),
    .i_upd_id    (r_id),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  // Gating with reset keeps ready low while reset is held with valid high.
  assign w_grant = (r_state == ST_IDLE) && w_gnt_valid && reset;
  assign w_op    = w_gnt_id ? r1_op   : r0_op;
  assign w_data  = w_gnt_id ? r1_data : r0_data;
  assign w_ovf   = (w_op == OP_PUSH) && ((r_occ == CNT_W'(DEPTH)) || stk_full);
  assign w_unf   = (w_op == OP_POP)  && ((r_occ == '0) || stk_empty);
  assign w_resp  = (r_state == ST_RESP);
  assign w_issue = (r_state == ST_ISSUE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_id       <= 1'b0;
      r_op       <= OP_PUSH;
      r_err      <= 1'b0;
      r_data     <= '0;
      r_rsp_data <= '0;
      r_occ      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_id       <= w_gnt_id;
            r_op       <= w_op;
            r_data     <= w_data;
            r_rsp_data <= '0;
            r_err      <= w_ovf | w_unf;
            r_state    <= (w_ovf | w_unf) ? ST_RESP : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_op == OP_PUSH) begin
            r_occ   <= r_occ + CNT_W'(1);
            r_state <= ST_RESP;
          end else begin
            r_occ   <= r_occ - CNT_W'(1);
            r_state <= ST_WAIT_POP;
          end
        end
        ST_WAIT_POP: begin
          r_rsp_data <= stk_data_out;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign r0_ready     = w_grant && !w_gnt_id;
  assign r1_ready     = w_grant &&  w_gnt_id;
  assign r0_rsp_valid = w_resp && !r_id;
  assign r1_rsp_valid = w_resp &&  r_id;
  assign r0_rsp_data  = r0_rsp_valid ? r_rsp_data : '0;
  assign r1_rsp_data  = r1_rsp_valid ? r_rsp_data : '0;
  assign r0_err       = r0_rsp_valid && r_err;
  assign r1_err       = r1_rsp_valid && r_err;
  assign stk_push     = w_issue && (r_op == OP_PUSH);
  assign stk_pop      = w_issue && (r_op == OP_POP);
  assign stk_data_in  = w_issue ? r_data : '0;
  assign occupancy    = r_occ;

endmodule
